// File: rtl/charge_controller.sv
// rtl/charge_controller.sv - coin-operated phone charging station control FSM
module charge_controller #(
    parameter int CLK_HZ        = 1000,
    parameter int MAX_MONEY     = 20,
    parameter int TIMEOUT_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_value,
    input  logic       press,
    input  logic       clear,
    input  logic       start,
    input  logic       confirm,
    output logic       no_display,
    output logic [4:0] all_money,
    output logic [5:0] remaining_time,
    output logic [2:0] current_state
);

    localparam int TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int IW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS + 1) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_HZ - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INPUT    = 3'd1,
        S_CHARGING = 3'd2
    } state_t;

    state_t        state, state_n;
    logic [4:0]    money, money_n;
    logic [5:0]    rtime, rtime_n;
    logic [TW-1:0] tick, tick_n;
    logic [IW-1:0] idle, idle_n;
    logic          blank;

    // Strobe vectors ordered {press, clear, start, confirm}
    logic [3:0]    strobe_s, strobe_p;
    logic [3:0]    key_s;
    logic          ev_press, ev_clear, ev_start, ev_confirm;
    logic          key_ok;
    logic [7:0]    calc;

    // Sample strobes and key once, keep the previous sample for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_s <= 4'b0;
            strobe_p <= 4'b0;
            key_s    <= 4'b0;
        end else begin
            strobe_s <= {press, clear, start, confirm};
            strobe_p <= strobe_s;
            key_s    <= key_value;
        end
    end

    assign ev_press   = strobe_s[3] & ~strobe_p[3];
    assign ev_clear   = strobe_s[2] & ~strobe_p[2];
    assign ev_start   = strobe_s[1] & ~strobe_p[1];
    assign ev_confirm = strobe_s[0] & ~strobe_p[0];
    assign key_ok     = (key_s <= 4'd9);
    assign calc       = 8'(money) * 8'd10 + 8'(key_s);

    // State, amount, time and counters register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            money <= 5'd0;
            rtime <= 6'd0;
            tick  <= '0;
            idle  <= '0;
            blank <= 1'b1;
        end else begin
            state <= state_n;
            money <= money_n;
            rtime <= rtime_n;
            tick  <= tick_n;
            idle  <= idle_n;
            blank <= (state_n == S_IDLE);
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_n = state;
        money_n = money;
        rtime_n = rtime;
        tick_n  = tick;
        idle_n  = idle;
        case (state)
            S_IDLE: begin
                money_n = 5'd0;
                rtime_n = 6'd0;
                tick_n  = '0;
                idle_n  = '0;
                if (ev_start) begin
                    state_n = S_INPUT;
                end
            end
            S_INPUT: begin
                if (ev_clear) begin
                    money_n = 5'd0;
                    rtime_n = 6'd0;
                    tick_n  = '0;
                    idle_n  = '0;
                end else if (ev_confirm && money != 5'd0) begin
                    state_n = S_CHARGING;
                    rtime_n = {money, 1'b0};
                    tick_n  = '0;
                    idle_n  = '0;
                end else if (ev_press && key_ok) begin
                    if (money == 5'd0) begin
                        money_n = {1'b0, key_s};
                    end else if (calc > 8'(MAX_MONEY)) begin
                        money_n = 5'(MAX_MONEY);
                    end else begin
                        money_n = calc[4:0];
                    end
                    rtime_n = {money_n, 1'b0};
                    tick_n  = '0;
                    idle_n  = '0;
                end else if (tick == TICK_LAST) begin
                    tick_n = '0;
                    if (idle == IDLE_LAST) begin
                        state_n = S_IDLE;
                        money_n = 5'd0;
                        rtime_n = 6'd0;
                        idle_n  = '0;
                    end else begin
                        idle_n = idle + IW'(1);
                    end
                end else begin
                    tick_n = tick + TW'(1);
                end
            end
            S_CHARGING: begin
                if (tick == TICK_LAST) begin
                    tick_n = '0;
                    if (rtime <= 6'd1) begin
                        state_n = S_IDLE;
                        money_n = 5'd0;
                        rtime_n = 6'd0;
                    end else begin
                        rtime_n = rtime - 6'd1;
                    end
                end else begin
                    tick_n = tick + TW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                money_n = 5'd0;
                rtime_n = 6'd0;
                tick_n  = '0;
                idle_n  = '0;
            end
        endcase
    end

    assign no_display     = blank;
    assign all_money      = money;
    assign remaining_time = rtime;
    assign current_state  = state;

endmodule

// File: tb/tb_charge_controller.sv
// tb/tb_charge_controller.sv - table-driven self-checking bench for charge_controller
module tb_charge_controller;

    logic       clk;
    logic       rst_n;
    logic [3:0] key_value;
    logic       press, clear, start, confirm;
    logic       no_display;
    logic [4:0] all_money;
    logic [5:0] remaining_time;
    logic [2:0] current_state;

    int total = 0;
    int bad   = 0;

    charge_controller #(.CLK_HZ(1000), .MAX_MONEY(20), .TIMEOUT_TICKS(10)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_value     (key_value),
        .press         (press),
        .clear         (clear),
        .start         (start),
        .confirm       (confirm),
        .no_display    (no_display),
        .all_money     (all_money),
        .remaining_time(remaining_time),
        .current_state (current_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       cl;
        logic       cf;
        logic       pr;
        logic [3:0] key;
        int         e_state;
        int         e_money;
        int         e_time;
        int         e_nd;
    } vec_t;

    vec_t vt[21];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm, input int s, input int m, input int t, input int nd);
        check({nm, ".state"}, int'(current_state), s);
        check({nm, ".money"}, int'(all_money), m);
        check({nm, ".time"}, int'(remaining_time), t);
        check({nm, ".no_display"}, int'(no_display), nd);
    endtask

    // Raise the requested strobes for two edges, drop them, then idle two edges
    task automatic evt(input logic s, input logic c, input logic f, input logic p, input logic [3:0] k);
        @(negedge clk);
        start = s; clear = c; confirm = f; press = p; key_value = k;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0; clear = 1'b0; confirm = 1'b0; press = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        vt[0]  = '{0, 0, 0, 0, 4'd0,  0,  0,  0, 1};
        vt[1]  = '{0, 0, 0, 1, 4'd5,  0,  0,  0, 1};
        vt[2]  = '{1, 0, 0, 0, 4'd0,  1,  0,  0, 0};
        vt[3]  = '{0, 0, 1, 0, 4'd0,  1,  0,  0, 0};
        vt[4]  = '{0, 0, 0, 1, 4'd1,  1,  1,  2, 0};
        vt[5]  = '{0, 0, 0, 1, 4'd5,  1, 15, 30, 0};
        vt[6]  = '{0, 0, 0, 1, 4'd3,  1, 20, 40, 0};
        vt[7]  = '{0, 1, 0, 0, 4'd0,  1,  0,  0, 0};
        vt[8]  = '{0, 0, 0, 1, 4'd9,  1,  9, 18, 0};
        vt[9]  = '{0, 0, 0, 1, 4'd9,  1, 20, 40, 0};
        vt[10] = '{0, 0, 0, 1, 4'd12, 1, 20, 40, 0};
        vt[11] = '{0, 0, 0, 1, 4'd0,  1, 20, 40, 0};
        vt[12] = '{0, 1, 1, 0, 4'd0,  1,  0,  0, 0};
        vt[13] = '{0, 0, 0, 1, 4'd0,  1,  0,  0, 0};
        vt[14] = '{0, 0, 0, 1, 4'd2,  1,  2,  4, 0};
        vt[15] = '{1, 0, 0, 0, 4'd0,  1,  2,  4, 0};
        vt[16] = '{0, 0, 1, 0, 4'd0,  2,  2,  4, 0};
        vt[17] = '{0, 0, 0, 1, 4'd7,  2,  2,  4, 0};
        vt[18] = '{0, 1, 0, 0, 4'd0,  2,  2,  4, 0};
        vt[19] = '{1, 0, 0, 0, 4'd0,  2,  2,  4, 0};
        vt[20] = '{0, 0, 0, 1, 4'd1,  2,  2,  4, 0};

        rst_n = 1'b0;
        key_value = 4'd0; press = 1'b0; clear = 1'b0; start = 1'b0; confirm = 1'b0;
        repeat (3) @(negedge clk);
        check_all("reset_hold", 0, 0, 0, 1);
        rst_n = 1'b1;

        // Vector table: each record is one event followed by an output check
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            start = vt[i].st; clear = vt[i].cl; confirm = vt[i].cf;
            press = vt[i].pr; key_value = vt[i].key;
            @(negedge clk);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), vt[i].e_state, vt[i].e_money, vt[i].e_time, vt[i].e_nd);
            start = 1'b0; clear = 1'b0; confirm = 1'b0; press = 1'b0;
            repeat (2) @(negedge clk);
        end

        // Let the table's charge run out
        for (int i = 0; i < 5000 && current_state != 3'd0; i++) @(negedge clk);
        check_all("drain_end", 0, 0, 0, 1);

        // Exact charge timing for 2 yuan
        evt(1, 0, 0, 0, 4'd0);
        evt(0, 0, 0, 1, 4'd2);
        check_all("basic_pre", 1, 2, 4, 0);
        @(negedge clk);
        confirm = 1'b1;
        for (int i = 0; i < 10 && current_state != 3'd2; i++) @(negedge clk);
        confirm = 1'b0;
        check("basic_entry.state", int'(current_state), 2);
        n = 0;
        while (n < 2000 && remaining_time != 6'd3) begin
            @(negedge clk);
            n++;
        end
        check("basic_first_dec_cycles", n, 1000);
        while (n < 6000 && current_state != 3'd0) begin
            @(negedge clk);
            n++;
        end
        check("basic_total_cycles", n, 4000);
        check_all("basic_end", 0, 0, 0, 1);

        // Held key yields a single digit, then clear and re-entry
        evt(1, 0, 0, 0, 4'd0);
        @(negedge clk);
        press = 1'b1; key_value = 4'd1;
        repeat (10) @(negedge clk);
        press = 1'b0;
        repeat (2) @(negedge clk);
        check_all("held_key", 1, 1, 2, 0);
        evt(0, 1, 0, 0, 4'd0);
        check_all("held_clear", 1, 0, 0, 0);
        evt(0, 0, 0, 1, 4'd2);
        check_all("held_key2", 1, 2, 4, 0);
        evt(0, 0, 1, 0, 4'd0);
        check_all("held_confirm", 2, 2, 4, 0);

        // Reset mid-charge takes effect without a clock edge
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all("abort_reset", 0, 0, 0, 1);

        // Start held across reset release gives exactly one wake event
        start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        check_all("start_at_release", 1, 0, 0, 0);

        // Inactivity timeout back to IDLE
        repeat (9990) @(negedge clk);
        check("timeout_before.state", int'(current_state), 1);
        repeat (20) @(negedge clk);
        check("timeout_after.state", int'(current_state), 0);
        check("timeout_after.no_display", int'(no_display), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
